// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module : decode_pkg
// Brief  : Shared types and constants for the instruction-decode stage:
//          format enum, opcode constants and the decoded-bundle layout at the
//          default field widths.
// Rev    : 1.0  initial release
// ============================================================================
package decode_pkg;

  // Opcode assignments; everything from OP_RT_FIRST up to NOPS-1 is R-type.
  localparam int OP_IMM      = 0;
  localparam int OP_MOV      = 1;
  localparam int OP_LOAD     = 2;
  localparam int OP_STORE    = 3;
  localparam int OP_RT_FIRST = 4;

  // Default field widths, used by the bundle struct below.
  localparam int DEF_OPW  = 6;
  localparam int DEF_RW   = 5;
  localparam int DEF_AW   = 8;
  localparam int DEF_IMMW = 16;

  typedef enum logic [2:0] {
    FMT_IMM     = 3'd0,
    FMT_MOV     = 3'd1,
    FMT_LOAD    = 3'd2,
    FMT_STORE   = 3'd3,
    FMT_RTYPE   = 3'd4,
    FMT_ILLEGAL = 3'd5
  } fmt_e;

  // Decoded bundle at the default widths; field order matches the flat
  // vector carried through the skid buffer (opcode in the MSBs).
  typedef struct packed {
    logic [DEF_OPW-1:0]  opcode;
    fmt_e                fmt;
    logic [DEF_RW-1:0]   rdst2;
    logic [DEF_RW-1:0]   rdst1;
    logic [DEF_RW-1:0]   rsrc2;
    logic [DEF_RW-1:0]   rsrc1;
    logic [DEF_AW-1:0]   src_addr;
    logic [DEF_AW-1:0]   dst_addr;
    logic [DEF_IMMW-1:0] imm;
    logic                illegal;
  } decode_bundle_t;

endpackage : decode_pkg
`default_nettype wire

// File: rtl/decode_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : decode_skid_buf
// Brief  : Two-entry (output register + skid) valid/ready buffer on a flat
//          W-bit payload. Strict FIFO order, full throughput, flushable.
// Ports  : clk, rst_n (async active-low), flush
//          in_valid/in_ready/in_data    upstream side
//          out_valid/out_ready/out_data downstream side
// Rev    : 1.0  initial release
// ============================================================================
module decode_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;

  logic w_accept;
  logic w_slot_free;

  // in_ready comes straight from a flop, so it drops the cycle after the
  // skid entry fills.
  assign in_ready    = !skid_valid_q;
  assign w_accept    = in_valid && !skid_valid_q;
  assign w_slot_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_slot_free) begin
      // A full skid implies in_ready=0, so draining and accepting never
      // happen together here.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule : decode_skid_buf
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : instr_decode_stage
// Brief  : Registered instruction-decode stage. Splits each fetched word into
//          opcode/register/address/immediate fields, classifies its format,
//          zeroes unused fields and flags illegal opcodes. Valid/ready
//          handshake through a 2-entry skid buffer, flush, and a saturating
//          illegal-opcode counter.
// Ports  : clk, rst_n (async active-low), flush
//          in_valid/in_ready/in_instr   fetch side
//          out_valid/out_ready/out_*    decoded bundle
//          illegal_cnt                  accepted illegal words (saturating)
// Rev    : 1.0  initial release
// ============================================================================
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int IW   = 32,
  parameter int OPW  = 6,
  parameter int RW   = 5,
  parameter int AW   = 8,
  parameter int IMMW = 16,
  parameter int NOPS = 17,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_opcode,
  output logic [2:0]      out_fmt,
  output logic [RW-1:0]   out_rdst2,
  output logic [RW-1:0]   out_rdst1,
  output logic [RW-1:0]   out_rsrc2,
  output logic [RW-1:0]   out_rsrc1,
  output logic [AW-1:0]   out_src_addr,
  output logic [AW-1:0]   out_dst_addr,
  output logic [IMMW-1:0] out_imm,
  output logic            out_illegal,
  output logic [CNTW-1:0] illegal_cnt
);

  localparam int BW = OPW + 3 + 4*RW + 2*AW + IMMW + 1;

  // ---------------------------------------------------------------- decode
  logic [OPW-1:0]  w_opcode;
  fmt_e            w_fmt;
  logic [RW-1:0]   w_rdst2, w_rdst1, w_rsrc2, w_rsrc1;
  logic [AW-1:0]   w_src_addr, w_dst_addr;
  logic [IMMW-1:0] w_imm;
  logic            w_illegal;
  int              w_op_num;

  assign w_opcode = in_instr[IW-1 -: OPW];
  assign w_op_num = int'(w_opcode);

  always_comb begin
    w_fmt      = FMT_ILLEGAL;
    w_rdst2    = '0;
    w_rdst1    = '0;
    w_rsrc2    = '0;
    w_rsrc1    = '0;
    w_src_addr = '0;
    w_dst_addr = '0;
    w_imm      = '0;
    w_illegal  = 1'b0;
    if (w_op_num == OP_IMM) begin
      w_fmt   = FMT_IMM;
      w_rdst2 = in_instr[IW-OPW-1 -: RW];
      w_imm   = in_instr[IMMW-1:0];
    end else if (w_op_num == OP_MOV) begin
      w_fmt   = FMT_MOV;
      w_rdst2 = in_instr[IW-OPW-1 -: RW];
      w_rsrc2 = in_instr[RW-1:0];
    end else if (w_op_num == OP_LOAD) begin
      w_fmt      = FMT_LOAD;
      w_rdst2    = in_instr[IW-OPW-1 -: RW];
      w_src_addr = in_instr[AW-1:0];
    end else if (w_op_num == OP_STORE) begin
      w_fmt      = FMT_STORE;
      w_rsrc2    = in_instr[RW-1:0];
      w_dst_addr = in_instr[IW-OPW-1 -: AW];
    end else if (w_op_num >= OP_RT_FIRST && w_op_num < NOPS) begin
      w_fmt   = FMT_RTYPE;
      w_rdst2 = in_instr[IW-OPW-1 -: RW];
      w_rdst1 = in_instr[IW-OPW-RW-1 -: RW];
      w_rsrc2 = in_instr[2*RW-1:RW];
      w_rsrc1 = in_instr[RW-1:0];
    end else begin
      w_illegal = 1'b1;
    end
  end

  // ------------------------------------------------------------ skid buffer
  logic [BW-1:0] w_bundle_in;
  logic [BW-1:0] w_bundle_out;

  assign w_bundle_in = {w_opcode, w_fmt, w_rdst2, w_rdst1, w_rsrc2, w_rsrc1,
                        w_src_addr, w_dst_addr, w_imm, w_illegal};

  decode_skid_buf #(
    .W (BW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_bundle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_bundle_out)
  );

  assign {out_opcode, out_fmt, out_rdst2, out_rdst1, out_rsrc2, out_rsrc1,
          out_src_addr, out_dst_addr, out_imm, out_illegal} = w_bundle_out;

  // -------------------------------------------------------- illegal counter
  // Counts only words actually captured; a word presented alongside flush is
  // dropped and therefore not counted. Flush never clears the count.
  logic [CNTW-1:0] illegal_cnt_q, illegal_cnt_d;
  logic            w_count_en;

  assign w_count_en = in_valid && in_ready && !flush && w_illegal;

  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (w_count_en && (illegal_cnt_q != {CNTW{1'b1}})) begin
      illegal_cnt_d = illegal_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else begin
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign illegal_cnt = illegal_cnt_q;

endmodule : instr_decode_stage
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_decode_stage
// Brief  : Self-checking bench for instr_decode_stage: directed decode cases,
//          back-pressure, flush, counter saturation, async reset, and a
//          randomized run against a FIFO-style reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_opcode;
  logic [2:0]  out_fmt;
  logic [4:0]  out_rdst2, out_rdst1, out_rsrc2, out_rsrc1;
  logic [7:0]  out_src_addr, out_dst_addr;
  logic [15:0] out_imm;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_fmt(out_fmt),
    .out_rdst2(out_rdst2), .out_rdst1(out_rdst1),
    .out_rsrc2(out_rsrc2), .out_rsrc1(out_rsrc1),
    .out_src_addr(out_src_addr), .out_dst_addr(out_dst_addr),
    .out_imm(out_imm), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  // Second instance with a 4-bit counter so saturation is reachable quickly.
  logic        s_valid = 1'b0;
  logic        s_flush = 1'b0;
  logic        s_ordy = 1'b1;
  logic [31:0] s_instr = 32'hFC00_0000;
  logic        s_in_ready, s_out_valid, s_out_illegal;
  logic [5:0]  s_opcode;
  logic [2:0]  s_fmt;
  logic [4:0]  s_rdst2, s_rdst1, s_rsrc2, s_rsrc1;
  logic [7:0]  s_src, s_dst;
  logic [15:0] s_imm;
  logic [3:0]  s_cnt;

  instr_decode_stage #(.CNTW(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .in_valid(s_valid), .in_ready(s_in_ready), .in_instr(s_instr),
    .out_valid(s_out_valid), .out_ready(s_ordy),
    .out_opcode(s_opcode), .out_fmt(s_fmt),
    .out_rdst2(s_rdst2), .out_rdst1(s_rdst1),
    .out_rsrc2(s_rsrc2), .out_rsrc1(s_rsrc1),
    .out_src_addr(s_src), .out_dst_addr(s_dst),
    .out_imm(s_imm), .out_illegal(s_out_illegal), .illegal_cnt(s_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of expected bundles (head = output register).
  logic [63:0] m_q[$];
  logic [15:0] m_cnt = '0;
  int          n_dlv = 0;

  wire [63:0] dut_bundle = {2'b00, out_opcode, out_fmt, out_rdst2, out_rdst1,
                            out_rsrc2, out_rsrc1, out_src_addr, out_dst_addr,
                            out_imm, out_illegal};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode straight from the field rules, using shifts and masks.
  function automatic logic [63:0] model(input logic [31:0] w);
    int unsigned op, ra, rb, lo5, mid5, alo, ahi, imm;
    int unsigned fmt, d2, d1, s2, s1, sa, da, im, il;
    op = w >> 26; ra = (w >> 21) & 31; rb = (w >> 16) & 31;
    lo5 = w & 31; mid5 = (w >> 5) & 31; alo = w & 255; ahi = (w >> 18) & 255;
    imm = w & 16'hFFFF;
    fmt = 0; d2 = 0; d1 = 0; s2 = 0; s1 = 0; sa = 0; da = 0; im = 0; il = 0;
    if (op == 0)      begin fmt = 0; d2 = ra; im = imm; end
    else if (op == 1) begin fmt = 1; d2 = ra; s2 = lo5; end
    else if (op == 2) begin fmt = 2; d2 = ra; sa = alo; end
    else if (op == 3) begin fmt = 3; s2 = lo5; da = ahi; end
    else if (op < 17) begin fmt = 4; d2 = ra; d1 = rb; s2 = mid5; s1 = lo5; end
    else              begin fmt = 5; il = 1; end
    return {2'b00, op[5:0], fmt[2:0], d2[4:0], d1[4:0], s2[4:0], s1[4:0],
            sa[7:0], da[7:0], im[15:0], il[0]};
  endfunction

  // One clock: drive, check observed state against the model at negedge,
  // advance the model, then move to just after the rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic r, input logic f);
    logic acc, dlv;
    in_valid = v; in_instr = ins; out_ready = r; flush = f;
    @(negedge clk);
    chk("in_ready", in_ready, m_q.size() < 2);
    chk("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("bundle", dut_bundle, m_q[0]);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    acc = v && (m_q.size() < 2) && !f;
    dlv = (m_q.size() > 0) && r;
    if (f) begin
      m_q.delete();
    end else begin
      if (dlv) begin
        void'(m_q.pop_front());
        n_dlv++;
      end
      if (acc) begin
        m_q.push_back(model(ins));
        if ((ins >> 26) >= 17 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_fields"}, dut_bundle, 64'd0);
    chk({tag, "_cnt"}, illegal_cnt, 16'd0);
  endtask

  initial begin
    int base;
    logic [15:0] saved;
    logic [31:0] ins;

    // ---------------- reset
    #12;
    chk_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------------- directed decode cases
    step(1'b1, 32'h0041_1234, 1'b1, 1'b0);
    chk("imm_fmt", out_fmt, 3'd0);
    chk("imm_rdst2", out_rdst2, 5'd2);
    chk("imm_imm", out_imm, 16'h1234);
    chk("imm_zero", {out_rdst1, out_rsrc2, out_rsrc1, out_src_addr, out_dst_addr, out_illegal}, 0);

    step(1'b1, 32'h1067_0121, 1'b1, 1'b0);
    chk("rt_fields", {out_opcode, out_fmt, out_rdst2, out_rdst1, out_rsrc2, out_rsrc1},
        {6'd4, 3'd4, 5'd3, 5'd7, 5'd9, 5'd1});

    step(1'b1, 32'h0C94_0004, 1'b1, 1'b0);
    chk("st_fields", {out_fmt, out_dst_addr, out_rsrc2, out_rdst2, out_imm},
        {3'd3, 8'h25, 5'd4, 5'd0, 16'd0});

    step(1'b1, 32'hFC00_0000, 1'b1, 1'b0);
    chk("ill_fields", {out_fmt, out_illegal, out_rdst2, out_imm}, {3'd5, 1'b1, 5'd0, 16'd0});
    chk("ill_cnt", illegal_cnt, 16'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // ---------------- back-pressure and ordering
    base = n_dlv;
    step(1'b1, 32'h0400_0011, 1'b0, 1'b0);
    step(1'b1, 32'h0860_0022, 1'b0, 1'b0);
    chk("bp_in_ready_low", in_ready, 1'b0);
    step(1'b1, 32'h1400_0333, 1'b0, 1'b0);
    step(1'b1, 32'h1400_0333, 1'b1, 1'b0);
    step(1'b1, 32'h1400_0333, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp_delivered", n_dlv - base, 3);

    // ---------------- flush with two buffered words
    step(1'b1, 32'h0400_0044, 1'b0, 1'b0);
    step(1'b1, 32'h0400_0055, 1'b0, 1'b0);
    saved = illegal_cnt;
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b1);
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);
    chk("fl_cnt", illegal_cnt, saved);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // ---------------- counter saturation on the 4-bit instance
    s_valid = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("sat_14", s_cnt, 4'd14);
    repeat (1) @(posedge clk);
    #1;
    chk("sat_15", s_cnt, 4'd15);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", s_cnt, 4'd15);
    s_valid = 1'b0;

    // ---------------- randomized traffic
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:26] = 6'($urandom_range(0, 20));
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // ---------------- async reset mid-stream
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b0);
    step(1'b1, 32'h0041_1234, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    m_q.delete();
    m_cnt = '0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'h0841_0077, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_decode_stage
`default_nettype wire
